// File: rtl/spi_pwm_array_if.sv
// SPI pins feeding the PWM array: SCLK, COPI and nCS.
// The master drives them (bench or pad ring); the array only listens.
interface spi_pwm_array_if;
  logic SCLK;
  logic COPI;
  logic nCS;

  modport master (output SCLK, output COPI, output nCS);
  modport slave  (input  SCLK, input  COPI, input  nCS);
endinterface

// File: rtl/spi_pwm_array.sv
// NUM_CH-channel PWM/static output array configured over write-only SPI.
// Optional build macro PWM_STAGGER_EN gives each channel a constant phase offset of ch*STAGGER steps.
module spi_pwm_array #(
  parameter int NUM_CH      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEFAULT_DIV = 12,
  parameter int STAGGER     = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_pwm_array_if.slave      spi,
  output logic [NUM_CH-1:0]   out
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  logic [15:0]            sh_q, sh_d;
  logic [4:0]             bcnt_q, bcnt_d;
  logic                   wr_ok;
  logic [6:0]             addr;
  logic [7:0]             data;

  logic [NUM_CH-1:0]      en_out_q, en_out_d, en_pwm_q, en_pwm_d;
  logic [7:0]             pend_q [NUM_CH];
  logic [7:0]             pend_d [NUM_CH];
  logic [7:0]             duty_q [NUM_CH];
  logic [7:0]             duty_d [NUM_CH];
  logic [7:0]             div_q, div_d;
  logic                   psc_restart;

  logic [7:0]             psc_q, psc_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   tick, wrap;
  logic [NUM_CH-1:0]      out_q, out_d;

  // nCS idles high so its synchroniser resets to 1 to avoid a false frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.COPI};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.nCS};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  always_comb begin
    sh_d   = sh_q;
    bcnt_d = bcnt_q;
    if (ncs_fall) begin
      sh_d   = '0;
      bcnt_d = '0;
    end else if (!ncs_s && sclk_rise) begin
      sh_d = {sh_q[14:0], copi_s};
      if (bcnt_q != 5'd17) bcnt_d = bcnt_q + 5'd1;
    end
  end

  assign addr  = sh_q[14:8];
  assign data  = sh_q[7:0];
  assign wr_ok = ncs_rise && (bcnt_q == 5'd16) && sh_q[15];

  // Unmapped addresses match no branch below, so the frame is dropped implicitly.
  always_comb begin
    en_out_d    = en_out_q;
    en_pwm_d    = en_pwm_q;
    pend_d      = pend_q;
    div_d       = div_q;
    psc_restart = 1'b0;
    if (wr_ok) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (addr == 7'(ch / 8))     en_out_d[ch] = data[3'(ch % 8)];
        if (addr == 7'(8 + ch / 8)) en_pwm_d[ch] = data[3'(ch % 8)];
        if (addr == 7'(32 + ch))    pend_d[ch]   = data;
      end
      if (addr == 7'h7F) begin
        div_d       = data;
        psc_restart = 1'b1;
      end
    end
  end

  assign tick = (psc_q == div_q);
  assign wrap = tick && (cnt_q == 8'd254);

  always_comb begin
    psc_d = (tick || psc_restart) ? 8'd0 : psc_q + 8'd1;
    cnt_d = cnt_q;
    if (tick) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
    duty_d = duty_q;
    // Active duty only changes at the period boundary, taking the newest pending value.
    if (wrap) duty_d = pend_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [7:0] phase;
`ifdef PWM_STAGGER_EN
    localparam int OFF = (g * STAGGER) % 255;
    logic [8:0] sum;
    assign sum   = {1'b0, cnt_q} + 9'(OFF);
    assign phase = (sum >= 9'd255) ? 8'(sum - 9'd255) : sum[7:0];
`else
    assign phase = cnt_q;
`endif
    assign out_d[g] = en_out_q[g] &
                      (~en_pwm_q[g] | (duty_q[g] == 8'hFF) | (phase < duty_q[g]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q     <= '0;
      bcnt_q   <= '0;
      en_out_q <= '0;
      en_pwm_q <= '0;
      div_q    <= 8'(DEFAULT_DIV);
      psc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pend_q[ch] <= '0;
        duty_q[ch] <= '0;
      end
    end else begin
      sh_q     <= sh_d;
      bcnt_q   <= bcnt_d;
      en_out_q <= en_out_d;
      en_pwm_q <= en_pwm_d;
      div_q    <= div_d;
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      pend_q   <= pend_d;
      duty_q   <= duty_d;
    end
  end

  assign out = out_q;

endmodule

// File: doc/spi_pwm_array.md
Name: spi_pwm_array

Overview:
- Parametrised successor to the fixed 16-output SPI-configured PWM peripheral.
- Provides NUM_CH PWM/static outputs, programmed by write-only SPI transactions into an internal register map.
- Adds per-channel 8-bit duty cycle with period-aligned (glitch-free) updates, plus a runtime-programmable PWM prescaler.
- Instantiated directly by the tile top level, driving uo_out/uio_out.

Parameters:
NUM_CH, 16, number of output channels, legal 1..64
SYNC_STAGES, 2, flip-flop depth of the SCLK/COPI/nCS synchronisers, legal >=2
DEFAULT_DIV, 12, reset value of the prescaler register; a PWM tick occurs every DIV+1 clk cycles
STAGGER, 17, per-channel phase offset in counter steps (used only with PWM_STAGGER_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock, asynchronous to clk, mode 0
COPI  in  1  SPI data in, MSB first
nCS  in  1  SPI chip select, active low
out  out  NUM_CH  channel outputs, registered

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous, active-low (rst_n). All state is cleared on assertion.
- Reset values: out=0; all enable bits 0; all duty and pending-duty registers 0; prescaler=DEFAULT_DIV; PWM counter 0; SPI shifter, bit count and frame state cleared.
- Synchronisation:
  - SCLK, COPI and nCS each pass through SYNC_STAGES flops.
  - Edges are detected on synchronised values only.
  - Supported SCLK frequency is at most clk/4.
- SPI frame:
  - nCS low starts a frame and clears the bit count.
  - Each synchronised SCLK rising edge while nCS is low shifts in COPI; the bit count saturates at 17.
  - Frame format, MSB first: [15]=R/W (1=write), [14:8]=address, [7:0]=data.
- Commit: on synchronised nCS rising edge, the frame is committed only if bit count==16, bit15==1 and the address is mapped. The register updates on the following clk edge. Otherwise the frame is silently discarded (reads, short or long frames, unmapped addresses).
- Register map:
  - 0x00-0x07: en_out byte k, covering channels 8k..8k+7.
  - 0x08-0x0F: en_pwm byte k.
  - 0x20+ch: duty for channel ch.
  - 0x7F: prescaler.
  - Bytes or bits beyond NUM_CH are unmapped or ignored.
- Apply timing:
  - Enable and prescaler writes take effect on the clk edge after commit.
  - Duty writes go to a pending register. Pending is copied to active when the counter wraps 254->0. Back-to-back writes within one period: last wins.
- PWM engine:
  - Prescaler counter counts 0..DIV, then emits a one-cycle tick and restarts.
  - A prescaler write restarts the prescaler counter at 0.
  - DIV=0 gives a tick every clk.
  - The 8-bit PWM counter advances on each tick: 0..254, then wraps to 0 (255 steps per period).
- Output per channel, registered with one clk of latency:
  - en_out=0 -> 0.
  - else en_pwm=0 -> 1.
  - else duty==0xFF -> 1.
  - else (cnt < duty).
  - duty 0 -> constant 0.
- Reset mid-frame discards the frame. nCS rising mid-byte discards the frame. A new nCS falling edge always restarts the shifter.

Optional Feature:
- Macro: PWM_STAGGER_EN.
- Defined: channel ch compares duty against (cnt + ch*STAGGER) mod 255, computed with wrap-around and no divider (constant offsets), spreading edges across channels.
- Undefined: all channels compare against cnt, so rising edges of all active PWM channels align at cnt=0.
- Static, duty 0 and duty 0xFF cases are identical in both builds.

Test Plan:
1. Reset, then write 0x00=0xFF with NUM_CH=16 -> out[7:0]=0xFF, out[15:8]=0, one clk after the synchronised nCS rise; no PWM activity.
2. Write en_out0=0x01, en_pwm0=0x01, duty ch0=0x80, DIV=12 -> out[0] high 128 of every 255 ticks; period=255*13=3315 clk.
3. Change duty ch0 0x80->0x40 mid-period -> the current period completes at 128 high ticks; the next period has 64.
4. Send a 15-bit frame, a 17-bit frame, a read frame (bit15=0) and a write to 0x70 -> no register changes; out unchanged.
5. Set duty 0x00 and 0xFF on ch1 and ch2 with en_pwm set -> out[1] constantly 0, out[2] constantly 1 across 3 periods.
6. PWM_STAGGER_EN build, STAGGER=17, ch0/ch1 duty 0x80 -> ch1 rising edge leads ch0 by 17 ticks; both keep 128/255 duty.
